// File: rtl/aes_pkg.sv
// Shared AES byte type, affine constants and the forward/inverse affine maps.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  localparam aes_byte_t AES_AFF_C = 8'h63;
  localparam aes_byte_t AES_AFF_D = 8'h05;

  // Rotations implement bit i picking s[(i+k) mod 8].
  function automatic aes_byte_t aes_affine(input aes_byte_t s);
    return s ^ {s[3:0], s[7:4]} ^ {s[4:0], s[7:5]} ^ {s[5:0], s[7:6]} ^ {s[6:0], s[7]} ^ AES_AFF_C;
  endfunction

  function automatic aes_byte_t aes_affine_inv(input aes_byte_t b);
    return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ AES_AFF_D;
  endfunction

endpackage

// File: rtl/GF_MULINV_8.sv
// Combinational GF(2^8) multiplicative inverse over x^8+x^4+x^3+x+1, with inv(0) = 0.
// Computes a^254 by repeated squaring, so a zero input falls out as zero.
module GF_MULINV_8 (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] sq;
  logic [7:0] prod;

  // a^254 = product of a^(2^k) for k = 1..7
  always_comb begin
    sq   = a;
    prod = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq   = gf_mul(sq, sq);
      prod = gf_mul(prod, sq);
    end
    y = prod;
  end

endmodule

// File: rtl/aes_sbox_lane.sv
// One byte lane: S1 input transform (Ai when inverting) and S2 inverse plus affine.
// Mode ports exist only when built with AES_SUBBYTES_INV_EN.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  aes_byte_t s1_in,
`ifdef AES_SUBBYTES_INV_EN
  input  logic      s1_mode,
  input  logic      s2_mode,
`endif
  output aes_byte_t s1_out,
  input  aes_byte_t s2_in,
  output aes_byte_t s2_out
);

  aes_byte_t inv_b;

  GF_MULINV_8 u_inv (
    .a (s2_in),
    .y (inv_b)
  );

`ifdef AES_SUBBYTES_INV_EN
  assign s1_out = s1_mode ? aes_affine_inv(s1_in) : s1_in;
  assign s2_out = s2_mode ? inv_b : aes_affine(inv_b);
`else
  assign s1_out = s1_in;
  assign s2_out = aes_affine(inv_b);
`endif

endmodule

// File: rtl/aes_subbytes_pipe.sv
// LANES-wide AES SubBytes, two registered stages (latency 2), valid/ready holding up to 2 beats under stall.
// Define AES_SUBBYTES_INV_EN to make in_inv select InvSubBytes per beat; otherwise forward-only, out_inv = 0.
module aes_subbytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv
);

  localparam int W = 8 * LANES;

  logic         s1_valid;
  logic         s2_valid;
  logic         s2_adv;
  logic         in_acc;
  logic [W-1:0] s1_data;
  logic [W-1:0] s1_nxt;
  logic [W-1:0] s2_nxt;

  assign s2_adv    = s1_valid & (~s2_valid | out_ready);
  // flush drops the offered beat but still reports ready
  assign in_ready  = ~s1_valid | s2_adv | flush;
  assign in_acc    = in_valid & in_ready & ~flush;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_acc)      s1_valid <= 1'b1;
      else if (s2_adv) s1_valid <= 1'b0;
      if (s2_adv)         s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_acc) s1_data  <= s1_nxt;
    if (s2_adv) out_data <= s2_nxt;
  end

`ifdef AES_SUBBYTES_INV_EN
  logic s1_inv;

  always_ff @(posedge clk) begin
    if (in_acc) s1_inv <= in_inv;
  end

  always_ff @(posedge clk) begin
    if (rst)         out_inv <= 1'b0;
    else if (s2_adv) out_inv <= s1_inv;
  end
`else
  logic unused_inv;
  assign unused_inv = in_inv;
  assign out_inv    = 1'b0;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes_sbox_lane u_lane (
      .s1_in   (in_data[8*k +: 8]),
`ifdef AES_SUBBYTES_INV_EN
      .s1_mode (in_inv),
      .s2_mode (s1_inv),
`endif
      .s1_out  (s1_nxt[8*k +: 8]),
      .s2_in   (s1_data[8*k +: 8]),
      .s2_out  (s2_nxt[8*k +: 8])
    );
  end

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Directed bench for aes_subbytes_pipe: reset, known words, stalled stream, flush/reset, 1- and 16-lane builds.
module tb_aes_subbytes_pipe;

  logic         clk = 1'b0;
  logic         rst, flush;
  logic         in_valid, in_ready, in_inv;
  logic [31:0]  in_data;
  logic         out_valid, out_ready, out_inv;
  logic [31:0]  out_data;

  logic         w_valid, w_inv;
  logic         w1_in_ready, w1_out_valid, w1_out_inv;
  logic         w16_in_ready, w16_out_valid, w16_out_inv;
  logic [7:0]   w1_data, w1_out_data;
  logic [127:0] w16_data, w16_out_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] stim_q[$];
  logic [32:0] exp_q[$];

  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  always #5 clk = ~clk;

  aes_subbytes_pipe #(.LANES(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inv(out_inv));

  aes_subbytes_pipe #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(w_valid), .in_ready(w1_in_ready),
    .in_data(w1_data), .in_inv(w_inv), .out_valid(w1_out_valid), .out_ready(1'b1),
    .out_data(w1_out_data), .out_inv(w1_out_inv));

  aes_subbytes_pipe #(.LANES(16)) u_dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(w_valid), .in_ready(w16_in_ready),
    .in_data(w16_data), .in_inv(w_inv), .out_valid(w16_out_valid), .out_ready(1'b1),
    .out_data(w16_out_data), .out_inv(w16_out_inv));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sb4(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = sbox_rows[d[8*k+4 +: 4]][8*(15 - d[8*k +: 4]) +: 8];
    return r;
  endfunction

  // Drives stim_q, scores against exp_q; checks ready rule, held data and (unstalled) throughput.
  task automatic run_stream(input int stall_pct);
    logic [32:0] held;
    bit held_v;
    int occ, cyc, got, n;
    held = '0; held_v = 0; occ = 0; cyc = 0; got = 0; n = stim_q.size();
    while (got < n && cyc < 4000) begin
      in_valid = (stim_q.size() != 0);
      if (in_valid) {in_inv, in_data} = stim_q[0];
      out_ready = ($urandom_range(99) >= stall_pct);
      #1;
      chk("strm_in_ready", in_ready, out_ready || occ < 2);
      if (out_valid) begin
        if (held_v) chk("strm_held", {out_inv, out_data}, held);
        if (out_ready) begin
          chk("strm_data", {out_inv, out_data}, exp_q.pop_front());
          got++; occ--; held_v = 0;
        end else begin
          held = {out_inv, out_data}; held_v = 1;
        end
      end
      if (in_valid && in_ready) begin
        void'(stim_q.pop_front());
        occ++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    chk("strm_count", got, n);
    chk("strm_drained", out_valid, 0);
    if (stall_pct == 0) chk("strm_cycles", cyc, n + 2);
    stim_q.delete(); exp_q.delete();
  endtask

  task automatic kill_seq(input bit use_rst);
    out_ready = 0; in_inv = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = 32'h11223344 + i; #1;
      chk("kill_fill_rdy", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1; in_data = 32'hAAAAAAAA; #1;
    chk("kill_full_rdy", in_ready, 0);
    chk("kill_pre_valid", out_valid, 1);
    chk("kill_pre_data", out_data, sb4(32'h11223344));
    if (use_rst) rst = 1; else flush = 1;
    #1;
    if (!use_rst) chk("flush_rdy", in_ready, 1);
    @(posedge clk); #1;
    rst = 0; flush = 0; in_valid = 0;
    chk("kill_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("kill_empty", out_valid, 0);
    in_valid = 1; in_data = 32'h000153FF; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    chk("kill_next_valid", out_valid, 1);
    chk("kill_next_data", out_data, 32'h637CED16);
    @(posedge clk); #1;
    chk("kill_alone", out_valid, 0);
  endtask

  task automatic sweep(input logic [7:0] b, input logic inv, input logic [7:0] e, input logic e_inv);
    w_valid = 1; w_inv = inv; w1_data = b; w16_data = {16{b}}; #1;
    chk("w1_rdy", w1_in_ready, 1);
    chk("w16_rdy", w16_in_ready, 1);
    @(posedge clk); #1;
    w_valid = 0;
    @(posedge clk); #1;
    chk("w1_valid", w1_out_valid, 1);
    chk("w1_data", w1_out_data, e);
    chk("w1_inv", w1_out_inv, e_inv);
    chk("w16_valid", w16_out_valid, 1);
    chk("w16_data", w16_out_data, {16{e}});
    chk("w16_inv", w16_out_inv, e_inv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    rst = 1; flush = 0; in_valid = 1; in_data = 32'hDEADBEEF; in_inv = 0; out_ready = 1;
    w_valid = 0; w_inv = 0; w1_data = 8'h00; w16_data = '0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
    end
    chk("rst_out_inv", out_inv, 0);
    rst = 0; in_valid = 0; #1;
    chk("rel_in_ready", in_ready, 1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rel_out_valid", out_valid, 0);
    end

    // Single forward word, exact latency
    in_valid = 1; in_data = 32'h000153FF; in_inv = 0; #1;
    chk("fwd_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("fwd_lat1", out_valid, 0);
    @(posedge clk); #1;
    chk("fwd_valid", out_valid, 1);
    chk("fwd_data", out_data, 32'h637CED16);
    chk("fwd_inv", out_inv, 0);
    @(posedge clk); #1;
    chk("fwd_retired", out_valid, 0);

`ifdef AES_SUBBYTES_INV_EN
    stim_q = '{{1'b0, 32'h000153FF}, {1'b1, 32'h637CED16}, {1'b0, 32'h637CED16}, {1'b1, 32'h000153FF}};
    exp_q  = '{{1'b0, 32'h637CED16}, {1'b1, 32'h000153FF}, {1'b0, 32'hFB105547}, {1'b1, 32'h5209507D}};
`else
    stim_q = '{{1'b1, 32'h000153FF}, {1'b0, 32'h637CED16}};
    exp_q  = '{{1'b0, 32'h637CED16}, {1'b0, 32'hFB105547}};
`endif
    run_stream(0);

    for (int i = 0; i < 256; i++) begin
      d = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
      stim_q.push_back({1'b0, d});
      exp_q.push_back({1'b0, sb4(d)});
    end
    run_stream(40);

    for (int i = 0; i < 64; i++) begin
      d = {8'(i * 7), 8'(i * 5 + 1), 8'(255 - i), 8'(i * 3)};
      stim_q.push_back({1'b0, d});
      exp_q.push_back({1'b0, sb4(d)});
    end
    run_stream(0);

    kill_seq(1'b0);
    kill_seq(1'b1);

    sweep(8'h53, 1'b0, 8'hED, 1'b0);
`ifdef AES_SUBBYTES_INV_EN
    sweep(8'hED, 1'b1, 8'h53, 1'b1);
`else
    sweep(8'h53, 1'b1, 8'hED, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
